life_grid_renderer: RTL and testbench



---
 rtl/life_grid_renderer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_life_grid_renderer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/life_grid_renderer.sv
// life_grid_renderer
//   Renders a toroidal Game of Life grid onto the 640x480 raster of an
//   upstream VGA timing generator. A new generation is computed during
//   vertical blanking, one cell per clock, so the visible image never tears.
//
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   hpos, vpos          raster position from the timing generator
//   hsync_in, vsync_in  syncs from the timing generator (lag hpos/vpos by 1)
//   run                 1 = evolve every GEN_FRAMES frames
//   step                one-cycle pulse, requests one generation while run=0
//   r, g, b             registered 2-bit colour, 2 cycles after hpos/vpos
//   hsync_out/vsync_out syncs delayed 1 cycle, aligned with r/g/b
//   busy                generation update in progress
//   generation          number of committed generations (wraps at 16 bits)
//
// Build option:
//   GRID_LINES_EN  when defined, the first pixel row/column of each cell is
//                  drawn blue (r=00 g=00 b=01) regardless of the cell state.
module life_grid_renderer #(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 12,
    parameter int CELL_PX    = 40,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int GEN_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        run,
    input  logic        step,
    output logic [1:0]  r,
    output logic [1:0]  g,
    output logic [1:0]  b,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        busy,
    output logic [15:0] generation
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);
    localparam int OFF_W = $clog2(CELL_PX);
    localparam int CW    = $clog2(GRID_W);
    localparam int RW    = $clog2(GRID_H);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(CELL_PX - 1);

    function automatic logic [CELLS-1:0] seed_f();
        logic [CELLS-1:0] s;
        s = {CELLS{1'b0}};
        // glider
        s[0 * GRID_W + 1]  = 1'b1;
        s[1 * GRID_W + 2]  = 1'b1;
        s[2 * GRID_W + 0]  = 1'b1;
        s[2 * GRID_W + 1]  = 1'b1;
        s[2 * GRID_W + 2]  = 1'b1;
        // blinker
        s[5 * GRID_W + 10] = 1'b1;
        s[5 * GRID_W + 11] = 1'b1;
        s[5 * GRID_W + 12] = 1'b1;
        return s;
    endfunction

    function automatic logic cell_at(input logic [CELLS-1:0] grid,
                                     input logic [CW-1:0] x,
                                     input logic [RW-1:0] y);
        return grid[IDX_W'(y * GRID_W + x)];
    endfunction

    function automatic logic [3:0] count8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    localparam logic [CELLS-1:0] SEED = seed_f();

    typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, COMMIT = 2'd2} state_t;

    state_t             state_r;
    logic [CELLS-1:0]   cur_r, nxt_r;
    logic [CW-1:0]      ux_r;
    logic [RW-1:0]      uy_r;
    logic [7:0]         frame_cnt_r;
    logic               step_pending_r;

    logic [OFF_W-1:0]   xoff_r, yoff_r, xoff_s, yoff_s;
    logic [9:0]         col_r, row_r, col_s, row_s;
    logic               vis_r, live_r;
`ifdef GRID_LINES_EN
    logic               line_r;
`endif

    // Horizontal in-cell offset and column for the current hpos, derived from
    // last cycle's values so no divider is needed.
    always_comb begin
        if (hpos == 10'd0) begin
            xoff_s = {OFF_W{1'b0}};
            col_s  = 10'd0;
        end else if (xoff_r == OFF_MAX) begin
            xoff_s = {OFF_W{1'b0}};
            col_s  = col_r + 10'd1;
        end else begin
            xoff_s = xoff_r + OFF_W'(1);
            col_s  = col_r;
        end
    end

    // Vertical offset and row advance once per line, on its hpos==0 cycle.
    always_comb begin
        if (hpos != 10'd0) begin
            yoff_s = yoff_r;
            row_s  = row_r;
        end else if (vpos == 10'd0) begin
            yoff_s = {OFF_W{1'b0}};
            row_s  = 10'd0;
        end else if (yoff_r == OFF_MAX) begin
            yoff_s = {OFF_W{1'b0}};
            row_s  = row_r + 10'd1;
        end else begin
            yoff_s = yoff_r + OFF_W'(1);
            row_s  = row_r;
        end
    end

    logic             visible_s, in_grid_s, cell_s;
    logic [IDX_W-1:0] pix_idx_s;
    assign visible_s = (hpos < 10'(H_VISIBLE)) && (vpos < 10'(V_VISIBLE));
    assign in_grid_s = (col_s < 10'(GRID_W)) && (row_s < 10'(GRID_H));
    assign pix_idx_s = IDX_W'(row_s * 10'(GRID_W) + col_s);
    assign cell_s    = in_grid_s ? cur_r[pix_idx_s] : 1'b0;

    // Two-stage pixel pipeline: stage 1 looks up the cell, stage 2 colours it.
    always_ff @(posedge clk) begin
        if (reset) begin
            xoff_r <= {OFF_W{1'b0}};
            yoff_r <= {OFF_W{1'b0}};
            col_r  <= 10'd0;
            row_r  <= 10'd0;
            vis_r  <= 1'b0;
            live_r <= 1'b0;
`ifdef GRID_LINES_EN
            line_r <= 1'b0;
`endif
            r <= 2'b00;
            g <= 2'b00;
            b <= 2'b00;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            xoff_r <= xoff_s;
            yoff_r <= yoff_s;
            col_r  <= col_s;
            row_r  <= row_s;
            vis_r  <= visible_s;
            live_r <= cell_s;
`ifdef GRID_LINES_EN
            line_r <= (xoff_s == {OFF_W{1'b0}}) || (yoff_s == {OFF_W{1'b0}});
            if (vis_r && line_r) begin
                r <= 2'b00; g <= 2'b00; b <= 2'b01;
            end else if (vis_r && live_r) begin
                r <= 2'b01; g <= 2'b11; b <= 2'b01;
            end else begin
                r <= 2'b00; g <= 2'b00; b <= 2'b00;
            end
`else
            if (vis_r && live_r) begin
                r <= 2'b01; g <= 2'b11; b <= 2'b01;
            end else begin
                r <= 2'b00; g <= 2'b00; b <= 2'b00;
            end
`endif
            // hsync/vsync already lag hpos by one, so one more stage aligns them.
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

    // Trigger decode at the first vblank pixel.
    logic vblank_evt_s, frame_wrap_s, start_s;
    assign vblank_evt_s = (hpos == 10'd0) && (vpos == 10'(V_VISIBLE));
    assign frame_wrap_s = (frame_cnt_r == 8'(GEN_FRAMES - 1));
    assign start_s      = vblank_evt_s && (state_r == IDLE) &&
                          ((run && frame_wrap_s) || (!run && step_pending_r));

    // Neighbourhood of the cell being updated, wrapping at the grid edges.
    logic [CW-1:0]    xm_s, xp_s;
    logic [RW-1:0]    ym_s, yp_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [3:0]       n_s;
    logic             next_s, last_s;
    assign xm_s = (ux_r == {CW{1'b0}})    ? CW'(GRID_W - 1) : ux_r - CW'(1);
    assign xp_s = (ux_r == CW'(GRID_W - 1)) ? {CW{1'b0}}    : ux_r + CW'(1);
    assign ym_s = (uy_r == {RW{1'b0}})    ? RW'(GRID_H - 1) : uy_r - RW'(1);
    assign yp_s = (uy_r == RW'(GRID_H - 1)) ? {RW{1'b0}}    : uy_r + RW'(1);
    assign upd_idx_s = IDX_W'(uy_r * GRID_W + ux_r);
    assign n_s = count8({cell_at(cur_r, xm_s, ym_s), cell_at(cur_r, ux_r, ym_s),
                         cell_at(cur_r, xp_s, ym_s), cell_at(cur_r, xm_s, uy_r),
                         cell_at(cur_r, xp_s, uy_r), cell_at(cur_r, xm_s, yp_s),
                         cell_at(cur_r, ux_r, yp_s), cell_at(cur_r, xp_s, yp_s)});
    assign next_s = (n_s == 4'd3) || (cur_r[upd_idx_s] && (n_s == 4'd2));
    assign last_s = (ux_r == CW'(GRID_W - 1)) && (uy_r == RW'(GRID_H - 1));

    // Frame counting, step latching and the generation update FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            cur_r          <= SEED;
            nxt_r          <= {CELLS{1'b0}};
            ux_r           <= {CW{1'b0}};
            uy_r           <= {RW{1'b0}};
            frame_cnt_r    <= 8'd0;
            step_pending_r <= 1'b0;
            busy           <= 1'b0;
            generation     <= 16'd0;
        end else begin
            if (step && !run) begin
                step_pending_r <= 1'b1;
            end
            if (vblank_evt_s) begin
                frame_cnt_r <= frame_wrap_s ? 8'd0 : frame_cnt_r + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= UPDATE;
                        busy    <= 1'b1;
                        ux_r    <= {CW{1'b0}};
                        uy_r    <= {RW{1'b0}};
                        // A same-cycle step pulse is absorbed by this update.
                        if (!run) begin
                            step_pending_r <= 1'b0;
                        end
                    end
                end
                UPDATE: begin
                    nxt_r[upd_idx_s] <= next_s;
                    if (last_s) begin
                        state_r <= COMMIT;
                    end else if (ux_r == CW'(GRID_W - 1)) begin
                        ux_r <= {CW{1'b0}};
                        uy_r <= uy_r + RW'(1);
                    end else begin
                        ux_r <= ux_r + CW'(1);
                    end
                end
                COMMIT: begin
                    cur_r      <= nxt_r;
                    generation <= generation + 16'd1;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_life_grid_renderer.sv
module tb_life_grid_renderer;
    localparam int GW = 16, GH = 12, CP = 40, HV = 640, VV = 480, GF = 8;

    logic        clk, reset, hsync_in, vsync_in, run, step;
    logic [9:0]  hpos, vpos;
    logic [1:0]  r, g, b;
    logic        hsync_out, vsync_out, busy;
    logic [15:0] generation;

    life_grid_renderer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .run(run), .step(step),
        .r(r), .g(g), .b(b), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .busy(busy), .generation(generation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit  grid [GH][GW];
    int  m_gen, m_evt, busy_cnt;
    bit  m_pend, m_started;
    logic [5:0] prev_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) grid[y][x] = 1'b0;
        grid[0][1] = 1; grid[1][2] = 1; grid[2][0] = 1; grid[2][1] = 1; grid[2][2] = 1;
        grid[5][10] = 1; grid[5][11] = 1; grid[5][12] = 1;
        m_gen = 0; m_evt = 0; m_pend = 0;
    endtask

    task automatic life_step();
        bit nx [GH][GW];
        int n;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0)
                            n += int'(grid[(y + dy + GH) % GH][(x + dx + GW) % GW]);
                nx[y][x] = (n == 3) || (grid[y][x] && n == 2);
            end
        grid = nx;
    endtask

    function automatic logic [5:0] pix_exp(input int h, input int v);
        if (h >= HV || v >= VV) return 6'b000000;
`ifdef GRID_LINES_EN
        if (h % CP == 0 || v % CP == 0) return 6'b000001;
`endif
        return grid[v / CP][h / CP] ? 6'b011101 : 6'b000000;
    endfunction

    // One pixel clock: drive inputs, advance the model, sample after the edge.
    task automatic tick(input int h, input int v, input bit stp, input bit rst, input bit chk_pix);
        logic [5:0] e;
        logic hs_b, vs_b;
        hs_b = 1'($urandom);
        vs_b = 1'($urandom);
        hpos = 10'(h); vpos = 10'(v); step = stp; reset = rst;
        hsync_in = hs_b; vsync_in = vs_b;
        e = pix_exp(h, v);
        if (rst) begin
            model_reset();
        end else begin
            if (stp && !run) m_pend = 1;
            if (h == 0 && v == VV) begin
                m_evt++;
                m_started = run ? (m_evt % GF == 0) : m_pend;
                if (!run && m_started) m_pend = 0;
                if (m_started) begin
                    life_step();
                    m_gen = (m_gen + 1) % 65536;
                end
            end
        end
        @(posedge clk); #1;
        if (busy === 1'b1) busy_cnt++;
        check("hsync_out", 32'(hsync_out), rst ? 32'd0 : 32'(hs_b));
        check("vsync_out", 32'(vsync_out), rst ? 32'd0 : 32'(vs_b));
        if (chk_pix) check("rgb", 32'({r, g, b}), rst ? 32'd0 : 32'(prev_exp));
        prev_exp = rst ? 6'd0 : e;
        step = 1'b0;
        reset = 1'b0;
    endtask

    // One abbreviated frame: each line starts at hpos 0; sweep lines run full width.
    task automatic frame(input bit sweep, input bit stp_at_100);
        busy_cnt = 0;
        m_started = 0;
        for (int v = 0; v < VV; v++) begin
            if (sweep && (v % CP == CP / 2 || v == 0)) begin
                for (int h = 0; h <= 703; h++)
                    tick(h, v, 1'b0, 1'b0, (h % CP == CP / 2) || h == 0 || h == 639 || h == 700);
            end else begin
                tick(0, v, stp_at_100 && v == 100, 1'b0, 1'b1);
            end
        end
        for (int h = 0; h <= 230; h++) tick(h, VV, 1'b0, 1'b0, 1'b1);
        check("busy_cycles", 32'(busy_cnt), m_started ? 32'd193 : 32'd0);
        check("generation", 32'(generation), 32'(m_gen));
        for (int v = VV + 1; v < 525; v++) tick((v == 500) ? 0 : 0, v, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        run = 1'b0; step = 1'b0; reset = 1'b1; hpos = 10'd0; vpos = 10'd0;
        hsync_in = 1'b0; vsync_in = 1'b0; prev_exp = 6'd0;
        model_reset();

        tick(0, 0, 1'b0, 1'b1, 1'b1);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_gen", 32'(generation), 32'd0);

        frame(1'b1, 1'b0);              // seed image, no update
        frame(1'b0, 1'b1);              // single step
        frame(1'b1, 1'b0);              // generation 1 image
        for (int i = 0; i < 4; i++) frame(1'b0, 1'($urandom_range(0, 1)));
        frame(1'b1, 1'b0);

        // Free running: one generation every GF frames, step ignored.
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        run = 1'b1;
        for (int i = 0; i < 16; i++) frame(1'b0, i == 2 || i == 9);
        check("run_gen", 32'(generation), 32'd2);
        frame(1'b1, 1'b0);
        run = 1'b0;

        // Reset in the middle of an update.
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        for (int v = 0; v < VV; v++) tick(0, v, v == 100, 1'b0, 1'b1);
        for (int h = 0; h <= 50; h++) tick(h, VV, 1'b0, 1'b0, 1'b1);
        check("mid_busy", 32'(busy), 32'd1);
        tick(51, VV, 1'b0, 1'b1, 1'b1);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_gen", 32'(generation), 32'd0);
        tick(52, VV, 1'b0, 1'b0, 1'b1);
        check("post_reset_busy", 32'(busy), 32'd0);
        for (int v = VV + 1; v < 525; v++) tick(0, v, 1'b0, 1'b0, 1'b1);
        frame(1'b1, 1'b0);              // seed restored

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
